// File: rtl/ext_pkg.sv
// ext_pkg
//   Shared definitions for the immediate-extension path: the 3-bit
//   extension-mode type and its encodings. Imported by ext_core (decode)
//   and imm_ext_stage (control).
package ext_pkg;

    typedef logic [2:0] eop_t;

    localparam eop_t EOP_SEXT  = 3'b000;  // sign-extend full immediate
    localparam eop_t EOP_ZEXT  = 3'b001;  // zero-extend full immediate
    localparam eop_t EOP_LUI   = 3'b010;  // immediate in the top bits
    localparam eop_t EOP_BR    = 3'b011;  // sign-extended branch offset, shifted
    localparam eop_t EOP_SEXT8 = 3'b100;  // sign-extend low byte
    localparam eop_t EOP_ZEXT8 = 3'b101;  // zero-extend low byte
    localparam eop_t EOP_SEXTH = 3'b110;  // sign-extend low half
    localparam eop_t EOP_ZEXTH = 3'b111;  // zero-extend low half

endpackage

// File: rtl/ext_core.sv
// ext_core
//   Purely combinational immediate extender. Shared with the fetch-stage
//   branch-target adder, so it carries no state.
//   Ports:
//     imm   in   IMM_W   raw immediate
//     EOp   in   3       extension mode (ext_pkg encodings)
//     word  out  DATA_W  extended result
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IMM_W-1:0]  imm,
    input  eop_t              EOp,
    output logic [DATA_W-1:0] word
);

    localparam int H = IMM_W / 2;

    generate
        if ((IMM_W < 4) || (IMM_W % 2 != 0)) begin : g_bad_imm_w
            $error("ext_core: IMM_W must be even and at least 4");
        end
        if (DATA_W < IMM_W + BR_SHIFT) begin : g_bad_data_w
            $error("ext_core: DATA_W must be at least IMM_W + BR_SHIFT");
        end
    endgenerate

    logic        [7:0]        lo_byte;
    logic        [H-1:0]      lo_half;
    logic signed [IMM_W-1:0]  imm_s;
    logic signed [DATA_W-1:0] sext_full;
    logic signed [DATA_W-1:0] br_off;
    logic        [DATA_W-1:0] zext_full;

    // Immediates narrower than a byte are sign-extended up to 8 bits so the
    // byte modes still see a well-defined operand.
    generate
        if (IMM_W >= 8) begin : g_byte_direct
            assign lo_byte = imm[7:0];
        end else begin : g_byte_widen
            assign lo_byte = 8'($signed(imm));
        end
    endgenerate

    assign lo_half   = imm[H-1:0];
    assign imm_s     = $signed(imm);
    assign sext_full = DATA_W'(imm_s);
    assign zext_full = DATA_W'(imm);
    assign br_off    = sext_full <<< BR_SHIFT;

    always_comb begin
        word = '0;
        case (EOp)
            EOP_SEXT:  word = sext_full;
            EOP_ZEXT:  word = zext_full;
            EOP_LUI:   word = zext_full << (DATA_W - IMM_W);
            EOP_BR:    word = br_off;
            EOP_SEXT8: word = DATA_W'($signed(lo_byte));
            EOP_ZEXT8: word = DATA_W'(lo_byte);
            EOP_SEXTH: word = DATA_W'($signed(lo_half));
            EOP_ZEXTH: word = DATA_W'(lo_half);
            default:   word = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage
//   Registered immediate extender between decode and the ALU operand mux.
//   The extended word is computed at acceptance and held in a 2-entry skid
//   buffer (output register + skid register) so execute can stall without
//   losing or duplicating immediates. Only results are stored.
//   Ports:
//     clk        in   1       rising-edge clock
//     reset      in   1       asynchronous, active-high; clears all state
//     in_valid   in   1       imm/EOp valid
//     in_ready   out  1       stage can accept (registered)
//     imm        in   IMM_W   raw immediate
//     EOp        in   3       extension mode
//     out_valid  out  1       ext holds a valid result (registered)
//     out_ready  in   1       consumer accepts
//     ext        out  DATA_W  extended result (registered)
module imm_ext_stage
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        EOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] skid_reg;
    logic [DATA_W-1:0] new_word;
    logic              acc;
    logic              pop;
    logic              load_out;
    logic              out_from_skid;
    logic              load_skid;

    ext_core #(
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm  (imm),
        .EOp  (eop_t'(EOp)),
        .word (new_word)
    );

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid_q & out_ready;

    always_comb begin
        state_nx      = state;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (acc) begin
                    state_nx = ST_ONE;
                    load_out = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && !pop) begin
                    state_nx  = ST_TWO;
                    load_skid = 1'b1;
                end else if (acc && pop) begin
                    load_out = 1'b1;
                end else if (pop) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so nothing new can arrive
                if (pop) begin
                    state_nx      = ST_ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    // Status flags are registered copies of the next state so that in_ready
    // and out_valid come straight from flops with no path from out_ready.
    // Data registers load only on acceptance/skid drain, so X inputs with
    // in_valid low never reach ext.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_reg     <= '0;
            skid_reg    <= '0;
        end else begin
            state       <= state_nx;
            out_valid_q <= (state_nx != ST_EMPTY);
            in_ready_q  <= (state_nx != ST_TWO);
            if (load_out) begin
                out_reg <= out_from_skid ? skid_reg : new_word;
            end
            if (load_skid) begin
                skid_reg <= new_word;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ext       = out_reg;

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage
//   Directed bench for imm_ext_stage: default instance plus a
//   IMM_W=12 / DATA_W=24 / BR_SHIFT=1 variant.
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  eop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext;

    logic        v_in_valid;
    logic        v_in_ready;
    logic [11:0] v_imm;
    logic [2:0]  v_eop;
    logic        v_out_valid;
    logic        v_out_ready;
    logic [23:0] v_ext;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_ext_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .EOp       (eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext       (ext)
    );

    imm_ext_stage #(.IMM_W(12), .DATA_W(24), .BR_SHIFT(1)) dut_v (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v_in_valid),
        .in_ready  (v_in_ready),
        .imm       (v_imm),
        .EOp       (v_eop),
        .out_valid (v_out_valid),
        .out_ready (v_out_ready),
        .ext       (v_ext)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_8001 [8] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004,
                                  32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
    logic [31:0] exp_00f0 [8] = '{32'h000000F0, 32'h000000F0, 32'h00F00000, 32'h000003C0,
                                  32'hFFFFFFF0, 32'h000000F0, 32'hFFFFFFF0, 32'h000000F0};

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        imm         = '0;
        eop         = '0;
        out_ready   = 1'b0;
        v_in_valid  = 1'b0;
        v_imm       = '0;
        v_eop       = '0;
        v_out_ready = 1'b0;

        // reset state
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_ext", 64'(ext), 64'h0);
        chk("rst_in_ready2", 64'(in_ready), 64'h1);
        reset = 1'b0;
        tick();
        chk("idle_out_valid", 64'(out_valid), 64'h0);

        // mode sweep, streaming with out_ready=1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imm = 16'h8001;
            eop = 3'(i);
            tick();
            chk($sformatf("sweep8001_eop%0d_valid", i), 64'(out_valid), 64'h1);
            chk($sformatf("sweep8001_eop%0d", i), 64'(ext), 64'(exp_8001[i]));
        end
        for (int i = 0; i < 8; i++) begin
            imm = 16'h00F0;
            eop = 3'(i);
            tick();
            chk($sformatf("sweep00f0_eop%0d", i), 64'(ext), 64'(exp_00f0[i]));
        end
        in_valid = 1'b0;
        imm      = 'x;
        eop      = 'x;
        tick();
        chk("sweep_drain_valid", 64'(out_valid), 64'h0);
        chk("sweep_drain_ext_held", 64'(ext), 64'h000000F0);

        // back-to-back stream of 8 items, ZEXT
        in_valid = 1'b1;
        eop      = 3'b001;
        for (int i = 0; i < 8; i++) begin
            imm = 16'h0100 + 16'(i);
            tick();
            chk($sformatf("stream%0d_valid", i), 64'(out_valid), 64'h1);
            chk($sformatf("stream%0d_ext", i), 64'(ext), 64'h100 + 64'(i));
            chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'h1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", 64'(out_valid), 64'h0);

        // backpressure: A, B fill the buffer, C waits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        eop       = 3'b001;
        imm       = 16'h00AA;
        tick();
        chk("bp_A_ext", 64'(ext), 64'hAA);
        chk("bp_A_in_ready", 64'(in_ready), 64'h1);
        imm = 16'h00BB;
        tick();
        chk("bp_B_in_ready", 64'(in_ready), 64'h0);
        chk("bp_B_ext", 64'(ext), 64'hAA);
        imm = 16'h00CC;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d_ext", i), 64'(ext), 64'hAA);
            chk($sformatf("bp_hold%0d_in_ready", i), 64'(in_ready), 64'h0);
            chk($sformatf("bp_hold%0d_valid", i), 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_deliver_B", 64'(ext), 64'hBB);
        chk("bp_ready_again", 64'(in_ready), 64'h1);
        tick();
        chk("bp_deliver_C", 64'(ext), 64'hCC);
        chk("bp_C_valid", 64'(out_valid), 64'h1);
        in_valid = 1'b0;
        tick();
        chk("bp_no_dup", 64'(out_valid), 64'h0);

        // simultaneous accept and pop in ONE
        in_valid = 1'b1;
        imm      = 16'h0D0D;
        eop      = 3'b001;
        tick();
        chk("accpop_D", 64'(ext), 64'h0D0D);
        imm = 16'h0E0E;
        tick();
        chk("accpop_E", 64'(ext), 64'h0E0E);
        chk("accpop_in_ready", 64'(in_ready), 64'h1);
        in_valid = 1'b0;
        tick();
        chk("accpop_drain", 64'(out_valid), 64'h0);

        // reset while in TWO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm       = 16'h0F0F;
        tick();
        imm = 16'h0A0A;
        tick();
        chk("two_before_reset", 64'(in_ready), 64'h0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst2_out_valid", 64'(out_valid), 64'h0);
        chk("rst2_ext", 64'(ext), 64'h0);
        chk("rst2_in_ready", 64'(in_ready), 64'h1);
        tick();
        reset    = 1'b0;
        in_valid = 1'b1;
        imm      = 16'h0123;
        tick();
        chk("post_rst_item", 64'(ext), 64'h0123);
        chk("post_rst_valid", 64'(out_valid), 64'h1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_alone", 64'(out_valid), 64'h0);

        // parameter variant
        v_out_ready = 1'b1;
        v_in_valid  = 1'b1;
        v_imm       = 12'h801;
        v_eop       = 3'b011;
        tick();
        chk("var_br", 64'(v_ext), 64'hFFF002);
        v_eop = 3'b010;
        tick();
        chk("var_lui", 64'(v_ext), 64'h801000);
        v_in_valid = 1'b0;
        tick();
        chk("var_drain", 64'(v_out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
